// File: rtl/wdt_rst_mgr_pkg.sv
// wdt_rst_mgr_pkg: shared definitions for the watchdog reset manager.
//   wdt_state_e        : reset sequencer state (2-bit encoding)
//   CAUSE_POR/WDT/SW   : bit positions within rst_cause
package wdt_rst_mgr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ASSERT     = 2'd1,
    ST_REL_PERIPH = 2'd2
  } wdt_state_e;

  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_WDT = 1;
  localparam int unsigned CAUSE_SW  = 2;

endpackage

// File: rtl/wdt_rst_filt.sv
// wdt_rst_filt: qualifies the watchdog reset pulse.
//   clk, rst_n  : clock, synchronous active-low reset
//   wdt_sys_rst : raw watchdog reset pulse, active-high
//   wdt_evt     : single-cycle strobe in the cycle the pulse has been high
//                 for FILT_CYC consecutive cycles; at most one per pulse
module wdt_rst_filt #(
  parameter int unsigned FILT_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wdt_sys_rst,
  output logic wdt_evt
);

  localparam logic [7:0] SAT  = 8'(FILT_CYC);
  localparam logic [7:0] LAST = 8'(FILT_CYC - 1);

  logic [7:0] cnt;

  // Counter saturates at FILT_CYC, so the strobe condition can only be met
  // once until the input drops and clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (!wdt_sys_rst)
      cnt <= '0;
    else if (cnt != SAT)
      cnt <= cnt + 8'd1;
  end

  assign wdt_evt = wdt_sys_rst && (cnt == LAST);

endmodule

// File: rtl/wdt_rst_mgr.sv
// wdt_rst_mgr: merges POR, qualified watchdog and software reset requests,
// sequences periph/core reset release, records reset cause and forwards the
// watchdog interrupt to the CPU with an end-of-interrupt handshake.
//   clk, rst_n     : clock, synchronous active-low power-on reset
//   wdt_sys_rst    : watchdog reset pulse (filtered internally)
//   wdt_int        : watchdog interrupt level (rising edge raises irq)
//   sw_rst_req     : software reset request pulse (honoured only when idle)
//   cause_clr      : clears rst_cause (a simultaneous set wins)
//   irq_ack        : CPU acknowledge of irq
//   core_rst_n     : core reset, released REL_GAP cycles after periph
//   periph_rst_n   : peripheral reset
//   irq, wdt_eoi   : CPU interrupt level, end-of-interrupt pulse to watchdog
//   rst_cause      : sticky {sw, wdt, por}
//   busy           : reset sequence in progress
module wdt_rst_mgr
  import wdt_rst_mgr_pkg::*;
#(
  parameter int unsigned ASSERT_CYC = 16,
  parameter int unsigned REL_GAP    = 4,
  parameter int unsigned FILT_CYC   = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wdt_sys_rst,
  input  logic       wdt_int,
  input  logic       sw_rst_req,
  input  logic       cause_clr,
  input  logic       irq_ack,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       irq,
  output logic       wdt_eoi,
  output logic [2:0] rst_cause,
  output logic       busy
);

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(REL_GAP - 1);

  wdt_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       cause_nxt;
  logic             wdt_evt, wdt_acc, sw_acc;
  logic             wdt_int_q, int_rise, idle_stay;

  wdt_rst_filt #(.FILT_CYC(FILT_CYC)) u_filt (
    .clk         (clk),
    .rst_n       (rst_n),
    .wdt_sys_rst (wdt_sys_rst),
    .wdt_evt     (wdt_evt)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    wdt_acc   = 1'b0;
    sw_acc    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (wdt_evt || sw_rst_req) begin
          state_nxt = ST_ASSERT;
          wdt_acc   = wdt_evt;
          sw_acc    = sw_rst_req;
        end
      end
      ST_ASSERT: begin
        if (cnt == ASSERT_LAST) begin
          state_nxt = ST_REL_PERIPH;
          cnt_nxt   = '0;
        end
      end
      ST_REL_PERIPH: begin
        if (cnt == REL_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
    // A watchdog event mid-sequence restarts the assert phase.
    if (state != ST_IDLE && wdt_evt) begin
      state_nxt = ST_ASSERT;
      cnt_nxt   = '0;
      wdt_acc   = 1'b1;
    end
  end

  always_comb begin
    cause_nxt = cause_clr ? 3'b000 : rst_cause;
    if (wdt_acc) cause_nxt[CAUSE_WDT] = 1'b1;
    if (sw_acc)  cause_nxt[CAUSE_SW]  = 1'b1;
  end

  assign int_rise  = wdt_int && !wdt_int_q;
  // irq/eoi are only live while idle and not about to start a sequence.
  assign idle_stay = (state == ST_IDLE) && (state_nxt == ST_IDLE);

  // Outputs are registered from the next state so they change on the same
  // edge as the state transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      busy         <= 1'b1;
      irq          <= 1'b0;
      wdt_eoi      <= 1'b0;
      rst_cause    <= 3'b001;
      wdt_int_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      core_rst_n   <= (state_nxt == ST_IDLE);
      periph_rst_n <= (state_nxt != ST_ASSERT);
      busy         <= (state_nxt != ST_IDLE);
      rst_cause    <= cause_nxt;
      wdt_int_q    <= wdt_int;
      irq          <= idle_stay && (int_rise || (irq && !irq_ack));
      wdt_eoi      <= idle_stay && irq && irq_ack;
    end
  end

endmodule

// File: tb/tb_wdt_rst_mgr.sv
// tb_wdt_rst_mgr: self-checking bench for wdt_rst_mgr (default parameters).
// Observed vector = {core_rst_n, periph_rst_n, irq, wdt_eoi, busy, rst_cause}.
module tb_wdt_rst_mgr;

  logic       clk = 1'b0;
  logic       rst_n, wdt_sys_rst, wdt_int, sw_rst_req, cause_clr, irq_ack;
  logic       core_rst_n, periph_rst_n, irq, wdt_eoi, busy;
  logic [2:0] rst_cause;
  logic [7:0] dut_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      nm;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    string      nm;
    logic       wsr, wint, sw, clr, ack;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[17];

  wdt_rst_mgr #(
    .ASSERT_CYC (16),
    .REL_GAP    (4),
    .FILT_CYC   (2),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wdt_sys_rst  (wdt_sys_rst),
    .wdt_int      (wdt_int),
    .sw_rst_req   (sw_rst_req),
    .cause_clr    (cause_clr),
    .irq_ack      (irq_ack),
    .core_rst_n   (core_rst_n),
    .periph_rst_n (periph_rst_n),
    .irq          (irq),
    .wdt_eoi      (wdt_eoi),
    .rst_cause    (rst_cause),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign dut_o = {core_rst_n, periph_rst_n, irq, wdt_eoi, busy, rst_cause};

  function automatic logic [7:0] oa(input logic [2:0] c);
    return {5'b00001, c};
  endfunction
  function automatic logic [7:0] orl(input logic [2:0] c);
    return {5'b01001, c};
  endfunction
  function automatic logic [7:0] oi(input logic q, input logic e, input logic [2:0] c);
    return {2'b11, q, e, 1'b0, c};
  endfunction

  // Expected value is queued when the cycle's stimulus is set, and popped
  // and compared just after the edge that produces it.
  task automatic step(input string nm, input logic [7:0] exp);
    exp_t e;
    exp_q.push_back('{nm: nm, val: exp});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (dut_o !== e.val) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b required %b", e.nm, $time, dut_o, e.val);
    end
  endtask

  task automatic expect_for(input string nm, input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) step(nm, exp);
  endtask

  task automatic idle_inputs();
    wdt_sys_rst = 1'b0; sw_rst_req = 1'b0; cause_clr = 1'b0; irq_ack = 1'b0;
  endtask

  // Two-cycle wdt pulse from IDLE with cause c_before, then full sequence.
  task automatic wdt_seq(input string nm, input logic [2:0] c_before, input logic [2:0] c_after);
    wdt_sys_rst = 1'b1;
    step({nm, "_pre"}, oi(1'b0, 1'b0, c_before));
    step({nm, "_evt"}, oa(c_after));
    wdt_sys_rst = 1'b0;
    expect_for({nm, "_assert"}, 15, oa(c_after));
    expect_for({nm, "_rel"}, 4, orl(c_after));
    step({nm, "_idle"}, oi(1'b0, 1'b0, c_after));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{"clr",        0,0,0,1,0, oi(0,0,3'b000)};
    tbl[1]  = '{"glitch",     1,0,0,0,0, oi(0,0,3'b000)};
    tbl[2]  = '{"glitch_end", 0,0,0,0,0, oi(0,0,3'b000)};
    tbl[3]  = '{"int_rise",   0,1,0,0,0, oi(1,0,3'b000)};
    tbl[4]  = '{"int_hold",   0,1,0,0,0, oi(1,0,3'b000)};
    tbl[5]  = '{"ack",        0,1,0,0,1, oi(0,1,3'b000)};
    tbl[6]  = '{"ack_noirq",  0,1,0,0,1, oi(0,0,3'b000)};
    tbl[7]  = '{"int_low",    0,0,0,0,0, oi(0,0,3'b000)};
    tbl[8]  = '{"int_rise2",  0,1,0,0,0, oi(1,0,3'b000)};
    tbl[9]  = '{"ack2",       0,0,0,0,1, oi(0,1,3'b000)};
    tbl[10] = '{"rise_ack0",  0,1,0,0,1, oi(1,0,3'b000)};
    tbl[11] = '{"irq_keep",   0,0,0,0,0, oi(1,0,3'b000)};
    tbl[12] = '{"rise_ack1",  0,1,0,0,1, oi(1,1,3'b000)};
    tbl[13] = '{"ack3",       0,1,0,0,1, oi(0,1,3'b000)};
    tbl[14] = '{"quiet",      0,0,0,0,0, oi(0,0,3'b000)};
    tbl[15] = '{"pulse2_a",   1,0,0,0,0, oi(0,0,3'b000)};
    tbl[16] = '{"pulse2_b",   1,0,0,0,0, oa(3'b010)};

    rst_n = 1'b0; wdt_int = 1'b0;
    idle_inputs();

    // Power-on reset and release sequence.
    expect_for("por_hold", 3, oa(3'b001));
    rst_n = 1'b1;
    expect_for("por_assert", 15, oa(3'b001));
    expect_for("por_rel", 4, orl(3'b001));
    step("por_idle", oi(0, 0, 3'b001));

    // Interrupt handshake and filter vectors in IDLE.
    foreach (tbl[i]) begin
      wdt_sys_rst = tbl[i].wsr; wdt_int = tbl[i].wint; sw_rst_req = tbl[i].sw;
      cause_clr = tbl[i].clr; irq_ack = tbl[i].ack;
      step(tbl[i].nm, tbl[i].exp);
    end
    idle_inputs(); wdt_int = 1'b0;
    expect_for("p2_assert", 15, oa(3'b010));
    expect_for("p2_rel", 4, orl(3'b010));
    step("p2_idle", oi(0, 0, 3'b010));

    // Long pulse: exactly one sequence.
    wdt_sys_rst = 1'b1;
    step("p10_pre", oi(0, 0, 3'b010));
    step("p10_evt", oa(3'b010));
    expect_for("p10_hold", 8, oa(3'b010));
    wdt_sys_rst = 1'b0;
    expect_for("p10_assert", 7, oa(3'b010));
    expect_for("p10_rel", 4, orl(3'b010));
    expect_for("p10_idle", 5, oi(0, 0, 3'b010));

    // Re-trigger during REL_PERIPH.
    wdt_sys_rst = 1'b1;
    step("rt_pre", oi(0, 0, 3'b010));
    step("rt_evt", oa(3'b010));
    wdt_sys_rst = 1'b0;
    expect_for("rt_assert", 15, oa(3'b010));
    step("rt_rel0", orl(3'b010));
    wdt_sys_rst = 1'b1;
    step("rt_rel1", orl(3'b010));
    step("rt_restart", oa(3'b010));
    wdt_sys_rst = 1'b0;
    expect_for("rt_assert2", 15, oa(3'b010));
    expect_for("rt_rel2", 4, orl(3'b010));
    step("rt_idle", oi(0, 0, 3'b010));

    // Reset asserted mid-sequence.
    wdt_sys_rst = 1'b1;
    step("mr_pre", oi(0, 0, 3'b010));
    step("mr_evt", oa(3'b010));
    wdt_sys_rst = 1'b0;
    expect_for("mr_assert", 15, oa(3'b010));
    expect_for("mr_rel", 2, orl(3'b010));
    rst_n = 1'b0;
    step("mr_rst", oa(3'b001));
    rst_n = 1'b1;
    expect_for("mr_assert2", 15, oa(3'b001));
    expect_for("mr_rel2", 4, orl(3'b001));
    step("mr_idle", oi(0, 0, 3'b001));

    // Build cause 3'b011, then clear+sw in the same cycle with irq pending.
    wdt_seq("c011", 3'b001, 3'b011);
    wdt_int = 1'b1;
    step("cp_irq", oi(1, 0, 3'b011));
    cause_clr = 1'b1; sw_rst_req = 1'b1;
    step("cp_clr_sw", oa(3'b100));
    idle_inputs(); wdt_int = 1'b0;
    step("cp_a1", oa(3'b100));
    wdt_int = 1'b1; sw_rst_req = 1'b1;
    step("cp_sw_ign", oa(3'b100));
    sw_rst_req = 1'b0;
    expect_for("cp_assert", 13, oa(3'b100));
    expect_for("cp_rel", 4, orl(3'b100));
    expect_for("cp_idle", 2, oi(0, 0, 3'b100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wdt_rst_mgr.md
Name: wdt_rst_mgr

Overview:
Receiving end of the watchdog's interrupt/reset outputs. It qualifies the watchdog reset pulse, merges it with power-on and software reset requests, and sequences the core and peripheral reset releases. It also records the reset cause, and turns the watchdog interrupt into a CPU-facing irq whose acknowledge is returned to the watchdog as an end-of-interrupt pulse. It sits in the always-on domain between the watchdog and the SoC reset tree.

Parameters:
ASSERT_CYC, 16, cycles both reset outputs are held low per event (>=1)
REL_GAP, 4, cycles between periph_rst_n release and core_rst_n release (>=1)
FILT_CYC, 2, consecutive high cycles of wdt_sys_rst needed to qualify it (1..255)
CNT_W, 8, width of internal sequencing counter (must hold max(ASSERT_CYC, REL_GAP))

Ports:
clk  in  1  single clock
rst_n  in  1  reset, synchronous, active-low (power-on reset)
wdt_sys_rst  in  1  watchdog reset pulse, active-high
wdt_int  in  1  watchdog interrupt level
sw_rst_req  in  1  software reset request, single-cycle pulse
cause_clr  in  1  clear rst_cause, single-cycle pulse
irq_ack  in  1  CPU acknowledge of irq
core_rst_n  out  1  core reset, active-low
periph_rst_n  out  1  peripheral reset, active-low
irq  out  1  watchdog interrupt to CPU, level
wdt_eoi  out  1  end-of-interrupt pulse to watchdog
rst_cause  out  3  sticky cause {sw, wdt, por}
busy  out  1  reset sequence in progress

Behaviour:
- All outputs registered. While rst_n=0 at a clk edge:
  - state=ASSERT, counter=0
  - core_rst_n=0, periph_rst_n=0, irq=0, wdt_eoi=0, busy=1
  - rst_cause=3'b001, filter state cleared
  - Reset mid-sequence behaves identically.
- FSM states: IDLE, ASSERT, REL_PERIPH.
  - ASSERT: both resets low. Counter counts ASSERT_CYC cycles, then moves to REL_PERIPH.
  - REL_PERIPH: periph_rst_n=1, core_rst_n=0. Counter counts REL_GAP cycles, then moves to IDLE.
  - IDLE: both resets high, busy=0.
- After rst_n release:
  - periph_rst_n rises on the ASSERT_CYC-th edge.
  - core_rst_n and busy change on the (ASSERT_CYC+REL_GAP)-th edge.
- Filter: a saturating counter increments while wdt_sys_rst=1 and clears when it is 0.
  - A qualified wdt event is a single-cycle strobe when the count reaches FILT_CYC.
  - At most one event per high pulse, however long the pulse is.
- Event acceptance:
  - In IDLE, a wdt event or sw_rst_req moves the FSM to ASSERT. Resets go low on the next edge.
  - A wdt event in ASSERT or REL_PERIPH restarts ASSERT with the counter reloaded. periph_rst_n is re-asserted on the next edge.
  - sw_rst_req outside IDLE is ignored and does not set its cause bit.
- Cause register:
  - An accepted event sets its bit: wdt=bit1, sw=bit2. Bits are sticky.
  - cause_clr clears all bits. A set in the same cycle wins over the clear.
  - Simultaneous wdt event and sw_rst_req in IDLE sets both bits.
- Interrupt path:
  - Edges are detected with a registered copy of wdt_int (reset value 0).
  - A rising edge while IDLE sets irq on the next edge.
  - irq_ack while irq=1 clears irq and pulses wdt_eoi for exactly one cycle on that edge.
  - irq_ack while irq=0 has no effect.
  - A new rising edge in the same cycle as the ack sets irq and wins, but wdt_eoi still pulses.
  - While busy, edges are ignored, irq is forced 0 and wdt_eoi is 0. Entering ASSERT clears irq.
- Counter width: CNT_W bits, no wrap. Terminal compare is ==param-1.

Decomposition:
- Package wdt_rst_mgr_pkg:
  - FSM state enum (2-bit encoding)
  - cause bit index constants CAUSE_POR=0, CAUSE_WDT=1, CAUSE_SW=2
- One natural sub-module: wdt_rst_filt (FILT_CYC qualifier with one-event-per-pulse arming).
- The FSM and irq logic stay in the top.

Test Plan:
- POR: hold rst_n=0 for 3 cycles, then release → periph_rst_n=1 at edge 16, core_rst_n=1 and busy=0 at edge 20, rst_cause=3'b001.
- Filter: in IDLE after cause_clr, a 1-cycle wdt_sys_rst glitch → no change. A 2-cycle pulse → both resets 0 on the edge after the 2nd high cycle, rst_cause=3'b010. A 10-cycle pulse → exactly one 20-cycle sequence.
- Re-trigger: a qualified wdt event arrives 2 cycles into REL_PERIPH → periph_rst_n=0 next edge, then a full 16+4 sequence from there.
- Interrupt: in IDLE, wdt_int rises → irq=1 next edge. irq_ack held 1 cycle → irq=0 and a 1-cycle wdt_eoi. A second ack → no wdt_eoi.
- Cause priority: cause_clr and sw_rst_req in the same IDLE cycle with rst_cause=3'b011 → rst_cause=3'b100 and a sequence starts. sw_rst_req during ASSERT → ignored, cause unchanged.
- Reset mid-sequence: rst_n=0 for one cycle during REL_PERIPH → next edge both resets 0, irq=0, rst_cause=3'b001, then a full POR sequence.
